// File: rtl/vc_pmem_arbiter_if.sv
// Bundle of L2, victim-cache and physical-memory signals around the
// pmem arbiter. master = requesters + memory, slave = the arbiter.
interface vc_pmem_arbiter_if #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
);
    logic              l2_pmem_read;
    logic              l2_pmem_write;
    logic [ADDR_W-1:0] l2_pmem_address;
    logic [LINE_W-1:0] l2_pmem_wdata;
    logic [LINE_W-1:0] l2_pmem_rdata;
    logic              l2_pmem_resp;

    logic              vc_pmem_write;
    logic [ADDR_W-1:0] vc_pmem_address;
    logic [LINE_W-1:0] vc_pmem_wdata;
    logic              vc_pmem_resp;

    logic              L2toPmem_busy;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        output l2_pmem_read, l2_pmem_write,
        output l2_pmem_address, l2_pmem_wdata,
        input  l2_pmem_rdata, l2_pmem_resp,
        output vc_pmem_write, vc_pmem_address,
        output vc_pmem_wdata,
        input  vc_pmem_resp, L2toPmem_busy,
        input  pmem_read, pmem_write,
        input  pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

    modport slave (
        input  l2_pmem_read, l2_pmem_write,
        input  l2_pmem_address, l2_pmem_wdata,
        output l2_pmem_rdata, l2_pmem_resp,
        input  vc_pmem_write, vc_pmem_address,
        input  vc_pmem_wdata,
        output vc_pmem_resp, L2toPmem_busy,
        output pmem_read, pmem_write,
        output pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/vc_pmem_arbiter.sv
// Single-port physical-memory arbiter: L2 has demand priority, a
// streak counter forces a pending victim-cache write-back through.
module vc_pmem_arbiter #(
    parameter int LINE_W       = 128,
    parameter int ADDR_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    vc_pmem_arbiter_if.slave   bus
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        L2_XFER,
        VC_XFER,
        L2_RESP,
        VC_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        streak_q, streak_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;

    logic l2_req;
    logic vc_req;
    logic starve;
    logic xfer;

    assign l2_req = bus.l2_pmem_read | bus.l2_pmem_write;
    assign vc_req = bus.vc_pmem_write;
    assign starve = (streak_q == LIMIT) & vc_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (starve || (!l2_req && vc_req)) begin
                    state_d  = VC_XFER;
                    streak_d = '0;
                    rd_d     = 1'b0;
                    addr_d   = bus.vc_pmem_address;
                    wdata_d  = bus.vc_pmem_wdata;
                end else if (l2_req) begin
                    state_d = L2_XFER;
                    // write wins when both L2 bits are up
                    rd_d    = bus.l2_pmem_read & ~bus.l2_pmem_write;
                    addr_d  = bus.l2_pmem_address;
                    wdata_d = bus.l2_pmem_wdata;
                    if (!vc_req)
                        streak_d = '0;
                    else if (streak_q != LIMIT)
                        streak_d = streak_q + 3'd1;
                end
            end
            L2_XFER: begin
                if (bus.pmem_resp) begin
                    state_d = L2_RESP;
                    rdata_d = bus.pmem_rdata;
                end
            end
            VC_XFER: begin
                if (bus.pmem_resp)
                    state_d = VC_RESP;
            end
            L2_RESP: state_d = IDLE;
            VC_RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign xfer = (state_q == L2_XFER) | (state_q == VC_XFER);

    assign bus.pmem_read     = xfer & rd_q;
    assign bus.pmem_write    = xfer & ~rd_q;
    assign bus.pmem_address  = addr_q;
    assign bus.pmem_wdata    = wdata_q;
    assign bus.l2_pmem_rdata = rdata_q;
    assign bus.l2_pmem_resp  = (state_q == L2_RESP);
    assign bus.vc_pmem_resp  = (state_q == VC_RESP);

    // combinational so the VC controller sees L2 demand the same cycle
    assign bus.L2toPmem_busy = l2_req
                             | (state_q == L2_XFER)
                             | (state_q == L2_RESP);

endmodule

// File: tb/tb_vc_pmem_arbiter.sv
// Directed test of vc_pmem_arbiter: fills, write-backs, priority,
// starvation relief, reset mid-transfer and dual L2 requests.
module tb_vc_pmem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vc_pmem_arbiter_if #(.LINE_W(128), .ADDR_W(16)) bus ();

    vc_pmem_arbiter #(
        .LINE_W(128),
        .ADDR_W(16),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] DA5 = {16{8'hA5}};
    localparam logic [127:0] DW1 = {4{32'h1111_2222}};
    localparam logic [127:0] DV1 = {4{32'h3333_4444}};
    localparam logic [127:0] DV2 = {4{32'h0C0C_5555}};
    localparam logic [127:0] DV5 = {4{32'h5A5A_0DDD}};
    localparam logic [127:0] DR3 = {4{32'hBEEF_0003}};
    localparam logic [127:0] DR5 = {4{32'hC3C3_0777}};
    localparam logic [127:0] DW6 = {4{32'h6666_0321}};
    localparam logic [127:0] DR6 = {4{32'h7777_0321}};

    logic [15:0] exp_addr [6];
    logic        exp_vc   [6];
    int          l2cnt;

    initial begin
        rst                 = 1'b1;
        bus.l2_pmem_read    = 1'b0;
        bus.l2_pmem_write   = 1'b0;
        bus.l2_pmem_address = '0;
        bus.l2_pmem_wdata   = '0;
        bus.vc_pmem_write   = 1'b0;
        bus.vc_pmem_address = '0;
        bus.vc_pmem_wdata   = '0;
        bus.pmem_rdata      = '0;
        bus.pmem_resp       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_rd",    128'(bus.pmem_read), 128'(0));
        check("rst_wr",    128'(bus.pmem_write), 128'(0));
        check("rst_addr",  128'(bus.pmem_address), 128'(0));
        check("rst_l2rsp", 128'(bus.l2_pmem_resp), 128'(0));
        check("rst_vcrsp", 128'(bus.vc_pmem_resp), 128'(0));
        check("rst_busy",  128'(bus.L2toPmem_busy), 128'(0));
        @(negedge clk) rst = 1'b0;
        tick();

        // L2 fill, memory answers in cycle 5
        bus.l2_pmem_read    = 1'b1;
        bus.l2_pmem_address = 16'h1234;
        #1;
        check("t1_busy0", 128'(bus.L2toPmem_busy), 128'(1));
        check("t1_rd0", 128'(bus.pmem_read), 128'(0));
        for (int c = 1; c <= 5; c++) begin
            tick();
            check($sformatf("t1_rd_c%0d", c), 128'(bus.pmem_read), 128'(1));
            check($sformatf("t1_ad_c%0d", c), 128'(bus.pmem_address), 128'(16'h1234));
            check($sformatf("t1_rsp_c%0d", c), 128'(bus.l2_pmem_resp), 128'(0));
            if (c == 5) begin
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = DA5;
            end
        end
        tick();
        bus.pmem_resp    = 1'b0;
        bus.pmem_rdata   = '0;
        check("t1_rsp6",   128'(bus.l2_pmem_resp), 128'(1));
        check("t1_rdata6", bus.l2_pmem_rdata, DA5);
        check("t1_rd6",    128'(bus.pmem_read), 128'(0));
        bus.l2_pmem_read = 1'b0;
        tick();
        check("t1_rsp7",  128'(bus.l2_pmem_resp), 128'(0));
        check("t1_rd7",   128'(bus.pmem_read), 128'(0));
        check("t1_busy7", 128'(bus.L2toPmem_busy), 128'(0));

        // simultaneous L2 write and VC write
        bus.l2_pmem_write   = 1'b1;
        bus.l2_pmem_address = 16'h0AAA;
        bus.l2_pmem_wdata   = DW1;
        bus.vc_pmem_write   = 1'b1;
        bus.vc_pmem_address = 16'h0BBB;
        bus.vc_pmem_wdata   = DV1;
        #1;
        check("t2_busy0", 128'(bus.L2toPmem_busy), 128'(1));
        tick();
        check("t2_wr1",   128'(bus.pmem_write), 128'(1));
        check("t2_ad1",   128'(bus.pmem_address), 128'(16'h0AAA));
        check("t2_wd1",   bus.pmem_wdata, DW1);
        check("t2_busy1", 128'(bus.L2toPmem_busy), 128'(1));
        tick();
        bus.pmem_resp = 1'b1;
        check("t2_busy2", 128'(bus.L2toPmem_busy), 128'(1));
        tick();
        bus.pmem_resp = 1'b0;
        check("t2_l2rsp3", 128'(bus.l2_pmem_resp), 128'(1));
        check("t2_vcrsp3", 128'(bus.vc_pmem_resp), 128'(0));
        check("t2_busy3",  128'(bus.L2toPmem_busy), 128'(1));
        bus.l2_pmem_write = 1'b0;
        tick();
        check("t2_wr4",    128'(bus.pmem_write), 128'(0));
        check("t2_l2rsp4", 128'(bus.l2_pmem_resp), 128'(0));
        check("t2_busy4",  128'(bus.L2toPmem_busy), 128'(0));
        tick();
        check("t2_wr5", 128'(bus.pmem_write), 128'(1));
        check("t2_ad5", 128'(bus.pmem_address), 128'(16'h0BBB));
        check("t2_wd5", bus.pmem_wdata, DV1);
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        check("t2_vcrsp6", 128'(bus.vc_pmem_resp), 128'(1));
        bus.vc_pmem_write = 1'b0;
        tick();
        check("t2_vcrsp7", 128'(bus.vc_pmem_resp), 128'(0));
        tick();
        check("t2_vcrsp8", 128'(bus.vc_pmem_resp), 128'(0));

        // starvation relief: L2 x4, VC, L2
        exp_addr = '{16'h0100, 16'h0101, 16'h0102,
                     16'h0103, 16'h0F00, 16'h0104};
        exp_vc   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        l2cnt = 0;
        bus.vc_pmem_write   = 1'b1;
        bus.vc_pmem_address = 16'h0F00;
        bus.vc_pmem_wdata   = DV1;
        bus.l2_pmem_read    = 1'b1;
        bus.l2_pmem_address = 16'h0100;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("t3_ad%0d", i), 128'(bus.pmem_address), 128'(exp_addr[i]));
            check($sformatf("t3_wr%0d", i), 128'(bus.pmem_write), 128'(exp_vc[i]));
            if (i == 3)
                check("t3_streak4", 128'(dut.streak_q), 128'(4));
            if (exp_vc[i])
                check("t3_streak0", 128'(dut.streak_q), 128'(0));
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = DR3;
            tick();
            bus.pmem_resp  = 1'b0;
            check($sformatf("t3_l2rsp%0d", i), 128'(bus.l2_pmem_resp), 128'(!exp_vc[i]));
            check($sformatf("t3_vcrsp%0d", i), 128'(bus.vc_pmem_resp), 128'(exp_vc[i]));
            if (bus.vc_pmem_resp)
                bus.vc_pmem_write = 1'b0;
            if (bus.l2_pmem_resp) begin
                l2cnt++;
                bus.l2_pmem_address = 16'h0100 + 16'(l2cnt);
            end
            if (i == 5)
                bus.l2_pmem_read = 1'b0;
            tick();
        end
        check("t3_rdata", bus.l2_pmem_rdata, DR3);

        // VC write-back with L2 quiet, memory answers in cycle 3
        bus.vc_pmem_write   = 1'b1;
        bus.vc_pmem_address = 16'h0C0C;
        bus.vc_pmem_wdata   = DV2;
        #1;
        check("t4_busy0", 128'(bus.L2toPmem_busy), 128'(0));
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("t4_wr_c%0d", c), 128'(bus.pmem_write), 128'(1));
            check($sformatf("t4_busy_c%0d", c), 128'(bus.L2toPmem_busy), 128'(0));
            check($sformatf("t4_vcrsp_c%0d", c), 128'(bus.vc_pmem_resp), 128'(0));
        end
        check("t4_ad", 128'(bus.pmem_address), 128'(16'h0C0C));
        check("t4_wd", bus.pmem_wdata, DV2);
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        check("t4_vcrsp4", 128'(bus.vc_pmem_resp), 128'(1));
        check("t4_wr4",    128'(bus.pmem_write), 128'(0));
        bus.vc_pmem_write = 1'b0;
        tick();
        check("t4_vcrsp5", 128'(bus.vc_pmem_resp), 128'(0));

        // reset during VC_XFER, stale pmem_resp afterwards
        bus.vc_pmem_write   = 1'b1;
        bus.vc_pmem_address = 16'h0DDD;
        bus.vc_pmem_wdata   = DV5;
        tick();
        check("t5_wr1", 128'(bus.pmem_write), 128'(1));
        check("t5_wd1", bus.pmem_wdata, DV5);
        bus.vc_pmem_write = 1'b0;
        rst = 1'b1;
        #1;
        check("t5_wr_r",    128'(bus.pmem_write), 128'(0));
        check("t5_rd_r",    128'(bus.pmem_read), 128'(0));
        check("t5_ad_r",    128'(bus.pmem_address), 128'(0));
        check("t5_wd_r",    bus.pmem_wdata, 128'(0));
        check("t5_rdata_r", bus.l2_pmem_rdata, 128'(0));
        check("t5_vcrsp_r", 128'(bus.vc_pmem_resp), 128'(0));
        @(negedge clk) rst = 1'b0;
        tick();
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        check("t5_vcrsp_a", 128'(bus.vc_pmem_resp), 128'(0));
        check("t5_wr_a",    128'(bus.pmem_write), 128'(0));
        tick();
        check("t5_vcrsp_b", 128'(bus.vc_pmem_resp), 128'(0));
        bus.l2_pmem_read    = 1'b1;
        bus.l2_pmem_address = 16'h0777;
        tick();
        check("t5_rd", 128'(bus.pmem_read), 128'(1));
        check("t5_ad", 128'(bus.pmem_address), 128'(16'h0777));
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = DR5;
        tick();
        bus.pmem_resp  = 1'b0;
        check("t5_l2rsp", 128'(bus.l2_pmem_resp), 128'(1));
        check("t5_rdata", bus.l2_pmem_rdata, DR5);
        bus.l2_pmem_read = 1'b0;
        tick();

        // dual L2 request: write first, read in the next arbitration
        bus.l2_pmem_read    = 1'b1;
        bus.l2_pmem_write   = 1'b1;
        bus.l2_pmem_address = 16'h0321;
        bus.l2_pmem_wdata   = DW6;
        tick();
        check("t6_wr1", 128'(bus.pmem_write), 128'(1));
        check("t6_rd1", 128'(bus.pmem_read), 128'(0));
        check("t6_wd1", bus.pmem_wdata, DW6);
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        check("t6_rsp2", 128'(bus.l2_pmem_resp), 128'(1));
        bus.l2_pmem_write = 1'b0;
        tick();
        check("t6_rd3", 128'(bus.pmem_read), 128'(0));
        check("t6_wr3", 128'(bus.pmem_write), 128'(0));
        tick();
        check("t6_rd4", 128'(bus.pmem_read), 128'(1));
        check("t6_wr4", 128'(bus.pmem_write), 128'(0));
        check("t6_ad4", 128'(bus.pmem_address), 128'(16'h0321));
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = DR6;
        tick();
        bus.pmem_resp  = 1'b0;
        check("t6_rsp5",   128'(bus.l2_pmem_resp), 128'(1));
        check("t6_rdata5", bus.l2_pmem_rdata, DR6);
        bus.l2_pmem_read = 1'b0;
        tick();
        check("t6_rsp6",  128'(bus.l2_pmem_resp), 128'(0));
        check("t6_busy6", 128'(bus.L2toPmem_busy), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
